// File: rtl/serial_subtractor_32_bit.sv
// serial_subtractor_32_bit
//   Bit-serial two's-complement subtractor. Computes d = a - b - bin one bit
//   per clock, LSB first. A single full-subtractor cell and a borrow flop are
//   reused for every bit. Results are registered and held until the next
//   completion.
//
//   State table
//     S_IDLE | waiting for start, accepts operands
//     S_RUN  | one bit processed per edge, busy_o=1
//     S_DONE | one-cycle done_o pulse, accepts a back-to-back start
//
// Ports
//   clk_i    rising-edge clock
//   rst_n_i  synchronous reset, active-low
//   start_i  request; operands sampled when accepted (IDLE or DONE)
//   a_i      minuend
//   b_i      subtrahend
//   bin_i    borrow in
//   busy_o   1 while in RUN
//   done_o   single-cycle pulse, result outputs just updated
//   d_o      difference (mod 2^WIDTH)
//   bout_o   borrow out (unsigned a < b + bin)
//   ovf_o    signed overflow
//   zero_o   d_o == 0

module serial_subtractor_32_bit #(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             start_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             bin_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] d_o,
    output logic             bout_o,
    output logic             ovf_o,
    output logic             zero_o
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] d_q, d_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             br_q, br_d;
    logic             bout_q, bout_d;
    logic             ovf_q, ovf_d;
    logic             zero_q, zero_d;

    logic             ai, bi, di, br_next, last_bit;
    logic [WIDTH-1:0] res_shift;

    assign ai       = a_sh_q[0];
    assign bi       = b_sh_q[0];
    assign di       = ai ^ bi ^ br_q;
    assign br_next  = (~ai & bi) | (~(ai ^ bi) & br_q);
    assign last_bit = (cnt_q == CW'(WIDTH - 1));

    // New bit enters at the MSB; after WIDTH shifts the cleared initial
    // contents have been fully displaced.
    assign res_shift = (res_q >> 1) | {di, {(WIDTH-1){1'b0}}};

    always_comb begin
        state_d = state_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        res_d   = res_q;
        cnt_d   = cnt_q;
        br_d    = br_q;
        d_d     = d_q;
        bout_d  = bout_q;
        ovf_d   = ovf_q;
        zero_d  = zero_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                state_d = S_IDLE;
                if (start_i) begin
                    state_d = S_RUN;
                    a_sh_d  = a_i;
                    b_sh_d  = b_i;
                    res_d   = '0;
                    br_d    = bin_i;
                    cnt_d   = '0;
                end
            end
            S_RUN: begin
                a_sh_d = a_sh_q >> 1;
                b_sh_d = b_sh_q >> 1;
                res_d  = res_shift;
                br_d   = br_next;
                cnt_d  = cnt_q + CW'(1);
                if (last_bit) begin
                    state_d = S_DONE;
                    d_d     = res_shift;
                    bout_d  = br_next;
                    // On the last bit ai/bi are the latched operand MSBs.
                    ovf_d   = (ai ^ bi) & (di ^ ai);
                    zero_d  = ~|res_shift;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q <= S_IDLE;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            res_q   <= '0;
            cnt_q   <= '0;
            br_q    <= 1'b0;
            d_q     <= '0;
            bout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            zero_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            res_q   <= res_d;
            cnt_q   <= cnt_d;
            br_q    <= br_d;
            d_q     <= d_d;
            bout_q  <= bout_d;
            ovf_q   <= ovf_d;
            zero_q  <= zero_d;
        end
    end

    assign busy_o = (state_q == S_RUN);
    assign done_o = (state_q == S_DONE);
    assign d_o    = d_q;
    assign bout_o = bout_q;
    assign ovf_o  = ovf_q;
    assign zero_o = zero_q;

endmodule

// File: tb/tb_serial_subtractor_32_bit.sv
// Bench for serial_subtractor_32_bit: transaction-level reference model with a
// per-cycle compare, literal checks on directed cases, then random operations.

module tb_serial_subtractor_32_bit;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] a = '0, b = '0;
    logic         bin = 1'b0;
    logic         busy, done, bout, ovf, zero;
    logic [W-1:0] d;

    int vectors = 0;
    int miscompares = 0;

    serial_subtractor_32_bit #(.WIDTH(W)) dut (
        .clk_i  (clk),
        .rst_n_i(rst_n),
        .start_i(start),
        .a_i    (a),
        .b_i    (b),
        .bin_i  (bin),
        .busy_o (busy),
        .done_o (done),
        .d_o    (d),
        .bout_o (bout),
        .ovf_o  (ovf),
        .zero_o (zero)
    );

    always #5 clk = ~clk;

    // Reference model: an accepted operation completes W edges later.
    int           run_left = 0;
    bit           mvalid = 0;
    logic [W-1:0] pa, pb, m_d;
    logic         pbin, m_busy, m_done, m_bout, m_ovf, m_zero;

    always @(posedge clk) begin
        if (!rst_n) begin
            run_left = 0;
            m_busy = 0; m_done = 0; m_d = '0; m_bout = 0; m_ovf = 0; m_zero = 0;
            mvalid = 1;
        end else begin
            m_done = 0;
            if (run_left > 0) begin
                run_left--;
                if (run_left == 0) begin
                    {m_bout, m_d} = {1'b0, pa} - {1'b0, pb} - {{W{1'b0}}, pbin};
                    m_ovf  = (pa[W-1] != pb[W-1]) && (m_d[W-1] != pa[W-1]);
                    m_zero = (m_d == '0);
                    m_done = 1;
                end
            end else if (start) begin
                pa = a; pb = b; pbin = bin;
                run_left = W;
            end
            m_busy = (run_left > 0);
        end
    end

    always @(negedge clk) begin
        if (mvalid) begin
            vectors++;
            if (busy !== m_busy || done !== m_done || d !== m_d ||
                bout !== m_bout || ovf !== m_ovf || zero !== m_zero) begin
                miscompares++;
                $display("FAIL cycle_model t=%0t: got busy=%b done=%b d=%h bout=%b ovf=%b zero=%b expected busy=%b done=%b d=%h bout=%b ovf=%b zero=%b",
                         $time, busy, done, d, bout, ovf, zero,
                         m_busy, m_done, m_d, m_bout, m_ovf, m_zero);
            end
        end
    end

    task automatic chk(string nm, logic [63:0] got, logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    task automatic wait_done(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!done && n < 40);
        vectors++;
        if (!done) begin
            miscompares++;
            $display("FAIL done_timeout: got no done after %0d cycles expected done", n);
        end
    endtask

    task automatic do_op(input logic [W-1:0] ta, input logic [W-1:0] tb,
                         input logic tbin, output int lat);
        @(negedge clk);
        start = 1; a = ta; b = tb; bin = tbin;
        @(negedge clk);
        start = 0; a = $urandom; b = $urandom; bin = 1'($urandom);
        wait_done(lat);
    endtask

    task automatic chk_res(string nm, logic [W-1:0] ed, logic eb, logic eo, logic ez);
        chk({nm, "_d"}, 64'(d), 64'(ed));
        chk({nm, "_flags"}, 64'({bout, ovf, zero}), 64'({eb, eo, ez}));
    endtask

    initial begin
        int lat, n, t_prev, intervals_ok, saw_done;
        logic [W-1:0] ra, rb;
        repeat (3) @(negedge clk);
        chk("reset_outputs", 64'({busy, done, bout, ovf, zero, d}), 64'(0));
        rst_n = 1;

        // T1
        do_op(32'd5, 32'd3, 1'b0, lat);
        chk("t1_latency", 64'(lat), 64'd32);
        chk_res("t1", 32'd2, 0, 0, 0);

        // T2
        do_op(32'd0, 32'd1, 1'b0, lat);
        chk_res("t2a", 32'hFFFF_FFFF, 1, 0, 0);
        do_op(32'h1234_5678, 32'h1234_5678, 1'b1, lat);
        chk_res("t2b", 32'hFFFF_FFFF, 1, 0, 0);

        // T3
        do_op(32'h8000_0000, 32'd1, 1'b0, lat);
        chk_res("t3a", 32'h7FFF_FFFF, 0, 1, 0);
        do_op(32'd7, 32'd7, 1'b0, lat);
        chk_res("t3b", 32'd0, 0, 0, 1);

        // T4: mid-run start is ignored
        @(negedge clk);
        start = 1; a = 32'd100; b = 32'd40; bin = 0;
        @(negedge clk);
        start = 0;
        repeat (9) @(negedge clk);
        start = 1; a = 32'd1; b = 32'd2; bin = 1;
        @(negedge clk);
        start = 0;
        wait_done(lat);
        chk_res("t4_ignored", 32'd60, 0, 0, 0);

        // T4: start held high, done every W+1 cycles
        @(negedge clk);
        start = 1; a = 32'd9; b = 32'd4; bin = 0;
        t_prev = -1; intervals_ok = 1; saw_done = 0; n = 0;
        while (saw_done < 3 && n < 150) begin
            @(negedge clk);
            n++;
            if (done) begin
                if (t_prev >= 0 && n - t_prev != W + 1) intervals_ok = 0;
                t_prev = n;
                saw_done++;
                if (saw_done == 3) start = 0;
            end
        end
        chk("t4_backtoback_count", 64'(saw_done), 64'd3);
        chk("t4_backtoback_period", 64'(intervals_ok), 64'd1);
        chk_res("t4_backtoback", 32'd5, 0, 0, 0);

        // T5: reset mid-run aborts
        @(negedge clk);
        start = 1; a = 32'd50; b = 32'd8; bin = 0;
        @(negedge clk);
        start = 0;
        repeat (14) @(negedge clk);
        rst_n = 0;
        @(negedge clk);
        chk("t5_abort_outputs", 64'({busy, done, bout, ovf, zero, d}), 64'(0));
        rst_n = 1;
        saw_done = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) saw_done = 1;
        end
        chk("t5_no_done", 64'(saw_done), 64'd0);
        do_op(32'd50, 32'd8, 1'b1, lat);
        chk_res("t5_fresh", 32'd41, 0, 0, 0);

        // T6: random operations, per-cycle model compare does the checking
        for (int i = 0; i < 1000; i++) begin
            ra = $urandom; rb = $urandom;
            case ($urandom_range(0, 7))
                0: rb = ra;
                1: ra = '0;
                2: rb = 32'hFFFF_FFFF;
                3: ra = {1'b1, ra[W-2:0]};
                default: ;
            endcase
            do_op(ra, rb, 1'($urandom), lat);
        end

        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
